// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, bus ACK levels and the bus-side state
// encoding used by both the master transmitter and the slave receiver.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;

  // Level seen on sda during the ninth clock
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line, plus a history flop
// so rise/fall are decoded from the last two synchronized samples.
module i2c_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  // Idle bus level is high, so everything resets to 1 to avoid a phantom edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_hist <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign level = r_sync[STAGES-1];
  assign rise  = r_sync[STAGES-1] & ~r_hist;
  assign fall  = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-side I2C slave: detects START/STOP, matches the 7-bit address,
// ACKs address and data bytes, and strobes each received byte to local logic.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h1A,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_rw,
  output logic                  busy,
  output logic                  stop_det
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [I2C_BYTE_W-1:0] w_shift_next;

  i2c_state_e            r_state;
  logic [3:0]            r_cnt;
  logic [I2C_BYTE_W-2:0] r_shift;
  logic                  r_sda_oe;
  logic [I2C_BYTE_W-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_rw;
  logic                  r_busy;
  logic                  r_stop_det;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_scl (
    .clk   (clk),
    .rst   (rst),
    .din   (scl),
    .level (w_scl_lvl),
    .rise  (w_scl_rise),
    .fall  (w_scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sda (
    .clk   (clk),
    .rst   (rst),
    .din   (sda),
    .level (w_sda_lvl),
    .rise  (w_sda_rise),
    .fall  (w_sda_fall)
  );

  // scl high in both samples == level high and not just risen; this also
  // rejects an sda edge that coincides with an scl edge
  assign w_start = w_sda_fall & w_scl_lvl & ~w_scl_rise;
  assign w_stop  = w_sda_rise & w_scl_lvl & ~w_scl_rise;

  assign w_shift_next = {r_shift, w_sda_lvl};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_rw    <= 1'b0;
      r_busy     <= 1'b0;
      r_stop_det <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_stop_det <= 1'b0;
      if (w_stop) begin
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_stop_det <= 1'b1;
      end else if (w_start) begin
        r_state  <= ST_ADDR;
        r_cnt    <= '0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_shift_next[I2C_BYTE_W-2:0];
              if (r_cnt == 4'd7) begin
                r_cnt <= '0;
                if (w_shift_next[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                  r_rx_rw <= w_sda_lvl;
                  r_state <= ST_ADDR_ACK;
                end else begin
                  r_state <= ST_IGNORE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          // sda_oe doubles as the ACK phase: first fall pulls low, second releases
          ST_ADDR_ACK, ST_DATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_DATA;
                r_cnt    <= '0;
              end
            end
          end
          ST_DATA: begin
            if (w_scl_rise) begin
              r_shift <= w_shift_next[I2C_BYTE_W-2:0];
              if (r_cnt == 4'd7) begin
                r_cnt      <= '0;
                r_rx_data  <= w_shift_next;
                r_rx_valid <= 1'b1;
                r_state    <= ST_DATA_ACK;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          ST_IDLE, ST_IGNORE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_rw    = r_rx_rw;
  assign busy     = r_busy;
  assign stop_det = r_stop_det;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-banged bus master drives transactions
// from a table, plus hand sequences for reset, repeated START and edge races.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       w_sda;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rw;
  logic       busy;
  logic       stop_det;

  assign w_sda = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (w_sda),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_rw    (rx_rw),
    .busy     (busy),
    .stop_det (stop_det)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rxq[$];
  int stop_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxq.push_back(rx_data);
    if (stop_det === 1'b1) stop_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Works from idle (scl high) and as a repeated START (scl low)
  task automatic i2c_start();
    wait_clk(1); sda_drv = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_drv = 1'b0;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(1); sda_drv = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(Q);
  endtask

  // simul: pre-drive ~b, then flip sda in the same instant scl rises
  task automatic bit_tx(input logic b, input bit simul);
    wait_clk(1);
    if (simul) begin
      sda_drv = ~b;
      wait_clk(Q);
      sda_drv = b;
      scl = 1'b1;
    end else begin
      sda_drv = b;
      wait_clk(Q);
      scl = 1'b1;
    end
    wait_clk(2*Q); scl = 1'b0;
  endtask

  task automatic ack_clk(output logic ack);
    wait_clk(1); sda_drv = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); ack = (w_sda == I2C_ACK);
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic byte_tx(input logic [7:0] v, input bit simul_first, output logic ack);
    for (int k = 7; k >= 0; k--) bit_tx(v[k], (k == 7) && simul_first);
    ack_clk(ack);
  endtask

  typedef struct {
    logic [6:0]      addr;
    logic            rw;
    int              nb;
    logic [2:0][7:0] d;
    logic            exp_ack;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic ack;

    tbl[0] = '{addr: 7'h1A, rw: 1'b0, nb: 1, d: {8'h00, 8'h00, 8'hA5}, exp_ack: 1'b1};
    tbl[1] = '{addr: 7'h1B, rw: 1'b0, nb: 1, d: {8'h00, 8'h00, 8'h55}, exp_ack: 1'b0};
    tbl[2] = '{addr: 7'h1A, rw: 1'b0, nb: 3, d: {8'h80, 8'hFF, 8'h01}, exp_ack: 1'b1};
    tbl[3] = '{addr: 7'h1A, rw: 1'b1, nb: 2, d: {8'h00, 8'h7E, 8'h00}, exp_ack: 1'b1};
    tbl[4] = '{addr: 7'h0D, rw: 1'b1, nb: 1, d: {8'h00, 8'h00, 8'h1A}, exp_ack: 1'b0};

    // Reset values
    wait_clk(3);
    chk("rst_sda_oe",   sda_oe,   0);
    chk("rst_rx_data",  rx_data,  0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_rw",    rx_rw,    0);
    chk("rst_busy",     busy,     0);
    chk("rst_stop_det", stop_det, 0);
    rst = 1'b0;
    wait_clk(4);

    // Reset while the address ACK is being driven
    i2c_start();
    chk("start_busy", busy, 1);
    for (int k = 7; k >= 0; k--) bit_tx(((8'h34 >> k) & 8'h01) != 0, 1'b0);
    wait_clk(1); sda_drv = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(1);
    chk("midrst_oe_before", sda_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy",   busy,   0);
    chk("midrst_valid",  rx_valid, 0);
    wait_clk(2); rst = 1'b0;
    wait_clk(Q); scl = 1'b0;
    rxq.delete();
    byte_tx(8'h77, 1'b0, ack);
    chk("midrst_no_ack", ack, 0);
    chk("midrst_no_busy", busy, 0);
    i2c_stop(); wait_clk(4);
    chk("midrst_no_rx", rxq.size(), 0);

    // Table-driven transactions
    for (int i = 0; i < 5; i++) begin
      rxq.delete();
      stop_cnt = 0;
      i2c_start();
      byte_tx({tbl[i].addr, tbl[i].rw}, 1'b0, ack);
      chk($sformatf("v%0d_addr_ack", i), ack, tbl[i].exp_ack);
      chk($sformatf("v%0d_busy_addr", i), busy, tbl[i].exp_ack);
      for (int b = 0; b < tbl[i].nb; b++) begin
        byte_tx(tbl[i].d[b], 1'b0, ack);
        chk($sformatf("v%0d_data%0d_ack", i, b), ack, tbl[i].exp_ack);
      end
      i2c_stop(); wait_clk(4);
      chk($sformatf("v%0d_stop_det", i), stop_cnt, 1);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      chk($sformatf("v%0d_n_valid", i), rxq.size(), tbl[i].exp_ack ? tbl[i].nb : 0);
      if (tbl[i].exp_ack) begin
        chk($sformatf("v%0d_rx_rw", i), rx_rw, tbl[i].rw);
        for (int b = 0; b < tbl[i].nb && b < rxq.size(); b++)
          chk($sformatf("v%0d_rx%0d", i, b), rxq[b], tbl[i].d[b]);
      end
    end

    // Repeated START after 5 data bits drops the partial byte
    rxq.delete();
    stop_cnt = 0;
    i2c_start();
    byte_tx({7'h1A, 1'b0}, 1'b0, ack);
    chk("rs_addr1_ack", ack, 1);
    for (int k = 0; k < 5; k++) bit_tx(k[0] == 1'b0, 1'b0);
    i2c_start();
    chk("rs_busy", busy, 1);
    chk("rs_no_partial", rxq.size(), 0);
    byte_tx({7'h1A, 1'b1}, 1'b0, ack);
    chk("rs_addr2_ack", ack, 1);
    byte_tx(8'h3C, 1'b0, ack);
    chk("rs_data_ack", ack, 1);
    i2c_stop(); wait_clk(4);
    chk("rs_n_valid", rxq.size(), 1);
    if (rxq.size() > 0) chk("rs_rx_data", rxq[0], 8'h3C);
    chk("rs_rx_rw", rx_rw, 1);
    chk("rs_stop_det", stop_cnt, 1);

    // sda flipping in the same sample as the scl rise is data, not START/STOP
    rxq.delete();
    stop_cnt = 0;
    i2c_start();
    byte_tx({7'h1A, 1'b0}, 1'b0, ack);
    chk("race_addr_ack", ack, 1);
    byte_tx(8'h5A, 1'b1, ack);
    chk("race_fall_ack", ack, 1);
    chk("race_fall_busy", busy, 1);
    byte_tx(8'hC3, 1'b1, ack);
    chk("race_rise_ack", ack, 1);
    chk("race_no_stop", stop_cnt, 0);
    chk("race_n_valid", rxq.size(), 2);
    if (rxq.size() > 1) begin
      chk("race_rx0", rxq[0], 8'h5A);
      chk("race_rx1", rxq[1], 8'hC3);
    end
    i2c_stop(); wait_clk(4);
    chk("race_stop_det", stop_cnt, 1);
    chk("race_busy_end", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
